hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage core. Sits beside the forwarding unit and sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Covers three cases that forwarding cannot: load-use bubbles, branch-redirect flushes and multi-cycle data-memory waits.
- Also implements a memory-wait timeout FSM and saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM state encoding, the control
// bundle driven to the pipeline registers and the NOP used for bubbles.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Instruction the pipeline registers load when told to flush or bubble (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
    logic ex_mem_hold;
    logic mem_wb_bubble;
  } ctrl_t;

  function automatic ctrl_t ctrl_frozen();
    ctrl_t c;
    c               = '0;
    c.pc_hold       = 1'b1;
    c.if_id_hold    = 1'b1;
    c.id_ex_hold    = 1'b1;
    c.ex_mem_hold   = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// Handshake: a data-memory access is pending while mem_req_MEM=1 and completes on the cycle mem_ready=1; no other signal here handshakes.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic [4:0]       rd_EX;
  logic             MemRead_EX;
  logic             RegWrite_EX;
  logic             branch_taken_EX;
  logic             mem_req_MEM;
  logic             mem_ready;
  logic             clr_cnt;
  logic             pc_hold;
  logic             IF_ID_hold;
  logic             IF_ID_flush;
  logic             ID_EX_hold;
  logic             ID_EX_flush;
  logic             EX_MEM_hold;
  logic             MEM_WB_bubble;
  logic             fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX, RegWrite_EX,
           branch_taken_EX, mem_req_MEM, mem_ready, clr_cnt,
    input  pc_hold, IF_ID_hold, IF_ID_flush, ID_EX_hold, ID_EX_flush, EX_MEM_hold,
           MEM_WB_bubble, fault, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX, RegWrite_EX,
           branch_taken_EX, mem_req_MEM, mem_ready, clr_cnt,
    output pc_hold, IF_ID_hold, IF_ID_flush, ID_EX_hold, ID_EX_flush, EX_MEM_hold,
           MEM_WB_bubble, fault, state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-wait
// freezes with a timeout FSM, plus stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           freeze;
  logic           lu;
  logic           hit_rs1, hit_rs2;
  ctrl_t          ctrl;

  assign freeze  = bus.mem_req_MEM & ~bus.mem_ready;
  assign hit_rs1 = bus.use_rs1_ID & (bus.rs1_ID == bus.rd_EX);
  assign hit_rs2 = bus.use_rs2_ID & (bus.rs2_ID == bus.rd_EX);
  assign lu      = bus.MemRead_EX & bus.RegWrite_EX & (bus.rd_EX != 5'd0) & (hit_rs1 | hit_rs2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = '0;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (!freeze) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Branch outranks load-use because the ID instruction it would stall is discarded anyway.
    if (!rst) begin
      ctrl = '0;
    end else if (state_q == ST_FAULT || freeze) begin
      ctrl = ctrl_frozen();
    end else if (bus.branch_taken_EX) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (lu) begin
      ctrl.pc_hold     = 1'b1;
      ctrl.if_id_hold  = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_hold       = ctrl.pc_hold;
  assign bus.IF_ID_hold    = ctrl.if_id_hold;
  assign bus.IF_ID_flush   = ctrl.if_id_flush;
  assign bus.ID_EX_hold    = ctrl.id_ex_hold;
  assign bus.ID_EX_flush   = ctrl.id_ex_flush;
  assign bus.EX_MEM_hold   = ctrl.ex_mem_hold;
  assign bus.MEM_WB_bubble = ctrl.mem_wb_bubble;
  assign bus.fault         = (state_q == ST_FAULT);
  assign bus.state         = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.pc_hold),
    .clr   (bus.clr_cnt),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.if_id_flush),
    .clr   (bus.clr_cnt),
    .count (bus.flush_cnt)
  );

endmodule
